// File: rtl/multi_pwm_converter_pkg.sv
// Shared helpers for the multi-channel PWM converter.
// Counter sizing, clamping and saturating negation.
package multi_pwm_converter_pkg;

    // Bits needed to count 0 .. n-1 (at least 1).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Limit v to the range [lo, hi].
    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Negate a w-bit signed value; the most negative value maps to the most positive.
    function automatic int sat_neg(input int v, input int w);
        int lim;
        lim = 1 << (w - 1);
        if (v == -lim) return lim - 1;
        return -v;
    endfunction

endpackage

// File: rtl/multi_pwm_converter_if.sv
// Command bus from the drive controller into the PWM converter.
// One valid strobe latches every channel command at once.
interface multi_pwm_converter_if #(
    parameter int NUM_CH = 2,
    parameter int CMD_W  = 8
);
    logic                      cmd_valid;
    logic [NUM_CH*CMD_W-1:0]   wheel_cmds;

    modport master (
        output cmd_valid,
        output wheel_cmds
    );

    modport slave (
        input cmd_valid,
        input wheel_cmds
    );
endinterface

// File: rtl/multi_pwm_converter_channel.sv
// One PWM channel: flip, slew-limited command, clamped width, compare.
// Width is only reloaded on the shared period boundary.
module multi_pwm_converter_channel
    import multi_pwm_converter_pkg::*;
#(
    parameter int CMD_W = 8,
    parameter int CW    = 15,
    parameter int ZERO  = 1500,
    parameter int SHIFT = 2,
    parameter int MIN_W = 1000,
    parameter int MAX_W = 2000,
    parameter int SLEW  = 8,
    parameter bit FLIP  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW-1:0]    count,
    input  logic             boundary,
    input  logic             load,
    input  logic             force_zero,
    input  logic [CMD_W-1:0] cmd,
    output logic             pwm
);
    localparam int EW = CMD_W + 1;
    localparam int WW = CW + 1;

    logic signed [CMD_W-1:0] cmd_in;
    logic signed [CMD_W-1:0] target;
    logic signed [EW-1:0]    eff;
    logic [WW-1:0]           width;
    int                      diff;
    int                      eff_new;
    int                      w_new;

    assign cmd_in = FLIP ? CMD_W'(sat_neg(int'($signed(cmd)), CMD_W))
                         : $signed(cmd);

    // Next effective command (slew-limited step) and the width it implies.
    always_comb begin
        diff    = int'(target) - int'(eff);
        eff_new = int'(target);
        if (SLEW != 0 && diff > SLEW)
            eff_new = int'(eff) + SLEW;
        else if (SLEW != 0 && diff < -SLEW)
            eff_new = int'(eff) - SLEW;
        w_new = clamp(ZERO + (eff_new >>> SHIFT), MIN_W, MAX_W);
    end

    // Target register: new command wins over the watchdog failsafe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            target <= '0;
        else if (load)
            target <= cmd_in;
        else if (force_zero)
            target <= '0;
    end

    // Effective command and width advance only at the period boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eff   <= '0;
            width <= WW'(clamp(ZERO, MIN_W, MAX_W));
        end else if (boundary) begin
            eff   <= EW'(eff_new);
            width <= WW'(w_new);
        end
    end

    // Registered compare keeps the pin free of combinational glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pwm <= 1'b0;
        else
            pwm <= ({1'b0, count} < width);
    end

endmodule

// File: rtl/multi_pwm_converter.sv
// Multi-channel servo/ESC PWM converter with a shared period counter.
// Holds the counter, boundary detect and command watchdog.
module multi_pwm_converter
    import multi_pwm_converter_pkg::*;
#(
    parameter int              NUM_CH          = 2,
    parameter int              CMD_W           = 8,
    parameter int              PERIOD          = 20000,
    parameter int              ZERO            = 1500,
    parameter int              SHIFT           = 2,
    parameter int              MIN_W           = 1000,
    parameter int              MAX_W           = 2000,
    parameter int              SLEW            = 8,
    parameter logic [NUM_CH-1:0] FLIPPED_MASK  = '0,
    parameter int              TIMEOUT_PERIODS = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 one_MHz_enable,
    multi_pwm_converter_if.slave cmd,
    output logic [NUM_CH-1:0]    wheel_signals,
    output logic                 period_start,
    output logic                 timed_out
);
    localparam int CW  = cnt_width(PERIOD);
    localparam int WDW = cnt_width(TIMEOUT_PERIODS + 1) + 1;

    logic [CW-1:0]  count;
    logic           boundary;
    logic [WDW-1:0] wd_count;
    logic           trip;

    assign boundary = one_MHz_enable && (count == CW'(PERIOD - 1));

    assign trip = (TIMEOUT_PERIODS != 0) && boundary
               && !cmd.cmd_valid && !timed_out
               && (wd_count == WDW'(TIMEOUT_PERIODS - 1));

    // Shared period counter advanced by the tick strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (one_MHz_enable)
            count <= boundary ? '0 : count + CW'(1);
    end

    // One-clock marker for each period wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            period_start <= 1'b0;
        else
            period_start <= boundary;
    end

    // Watchdog: boundaries since the last command; a command always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_count  <= '0;
            timed_out <= 1'b0;
        end else if (cmd.cmd_valid) begin
            wd_count  <= '0;
            timed_out <= 1'b0;
        end else if (trip) begin
            wd_count  <= '0;
            timed_out <= 1'b1;
        end else if (boundary && !timed_out) begin
            wd_count  <= wd_count + WDW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_pwm_converter_channel #(
            .CMD_W (CMD_W),
            .CW    (CW),
            .ZERO  (ZERO),
            .SHIFT (SHIFT),
            .MIN_W (MIN_W),
            .MAX_W (MAX_W),
            .SLEW  (SLEW),
            .FLIP  (FLIPPED_MASK[i])
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .count      (count),
            .boundary   (boundary),
            .load       (cmd.cmd_valid),
            .force_zero (trip),
            .cmd        (cmd.wheel_cmds[i*CMD_W +: CMD_W]),
            .pwm        (wheel_signals[i])
        );
    end

endmodule

// File: tb/tb_multi_pwm_converter.sv
// Bench for multi_pwm_converter: per-period pulse widths against a
// period-level reference model, plus reset and watchdog behaviour.
module tb_multi_pwm_converter;
    localparam int P = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic [1:0] wheel_signals;
    logic       period_start;
    logic       timed_out;

    multi_pwm_converter_if #(.NUM_CH(2), .CMD_W(8)) cmd_if ();

    multi_pwm_converter #(
        .NUM_CH(2), .CMD_W(8), .PERIOD(P), .ZERO(60), .SHIFT(2),
        .MIN_W(0), .MAX_W(100), .SLEW(8), .FLIPPED_MASK(2'b10),
        .TIMEOUT_PERIODS(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .one_MHz_enable (en),
        .cmd            (cmd_if),
        .wheel_signals  (wheel_signals),
        .period_start   (period_start),
        .timed_out      (timed_out)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Reference state: targets, effective commands, watchdog.
    int tgt [2];
    int eff [2];
    int wd;
    bit to;
    bit skip_bnd;

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int neg_sat(input int v);
        return (v == -128) ? 127 : -v;
    endfunction

    function automatic int exp_w(input int e);
        int q;
        int w;
        q = (e >= 0) ? e / 4 : -((-e + 3) / 4);
        w = 60 + q;
        if (w < 0) w = 0;
        if (w > 100) w = 100;
        return w;
    endfunction

    task automatic model_reset();
        tgt = '{0, 0};
        eff = '{0, 0};
        wd = 0;
        to = 1'b0;
        skip_bnd = 1'b0;
    endtask

    task automatic model_boundary();
        for (int c = 0; c < 2; c++) begin
            int d;
            d = tgt[c] - eff[c];
            if (d > 8) eff[c] = eff[c] + 8;
            else if (d < -8) eff[c] = eff[c] - 8;
            else eff[c] = tgt[c];
        end
        if (!to) begin
            wd++;
            if (wd == 4) begin
                to = 1'b1;
                tgt = '{0, 0};
            end
        end
    endtask

    task automatic model_cmd(input int c0, input int c1);
        tgt[0] = c0;
        tgt[1] = neg_sat(c1);
        wd = 0;
        to = 1'b0;
    endtask

    // Measure one full period of high time per channel; optionally issue a
    // command after sample idx (idx = P-2 lands exactly on the boundary).
    task automatic run_period(input string tag, input bit first,
                              input bit do_cmd, input int idx,
                              input int c0, input int c1);
        int h0 = 0;
        int h1 = 0;
        int e0;
        int e1;
        if (!first) begin
            if (!skip_bnd) model_boundary();
            chk({tag, "/pstart"}, int'(period_start), 1);
            chk({tag, "/timed_out"}, int'(timed_out), int'(to));
        end
        skip_bnd = 1'b0;
        e0 = exp_w(eff[0]);
        e1 = exp_w(eff[1]);
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            h0 += int'(wheel_signals[0]);
            h1 += int'(wheel_signals[1]);
            if (do_cmd && i == idx) begin
                cmd_if.wheel_cmds = {8'(c1), 8'(c0)};
                cmd_if.cmd_valid  = 1'b1;
            end else begin
                cmd_if.cmd_valid  = 1'b0;
            end
        end
        chk({tag, "/w0"}, h0, e0);
        chk({tag, "/w1"}, h1, e1);
        if (do_cmd) begin
            if (idx == P - 2) begin
                model_boundary();
                skip_bnd = 1'b1;
            end
            model_cmd(c0, c1);
        end
    endtask

    initial begin
        logic [7:0] r;
        int c0;
        int c1;
        int idx;
        bit dc;

        cmd_if.cmd_valid  = 1'b0;
        cmd_if.wheel_cmds = '0;
        model_reset();

        repeat (5) @(negedge clk);
        chk("rst/ws", int'(wheel_signals), 0);
        chk("rst/pstart", int'(period_start), 0);
        chk("rst/timed_out", int'(timed_out), 0);
        reset = 1'b1;

        run_period("boot", 1'b1, 1'b0, 0, 0, 0);
        run_period("idle", 1'b0, 1'b0, 0, 0, 0);

        for (int k = 0; k < 9; k++)
            run_period("ramp", 1'b0, 1'b1, $urandom_range(0, 97), 64, 64);

        for (int k = 0; k < 6; k++)
            run_period("sat", 1'b0, 1'b1, $urandom_range(0, 97), 0, -128);

        for (int k = 0; k < 14; k++) begin
            dc  = ($urandom_range(0, 3) != 0);
            idx = ($urandom_range(0, 3) == 0) ? P - 2 : $urandom_range(0, 97);
            r = 8'($urandom);
            c0 = int'($signed(r));
            r = 8'($urandom);
            c1 = int'($signed(r));
            run_period("rand", 1'b0, dc, idx, c0, c1);
        end

        for (int k = 0; k < 20; k++)
            run_period("wdog", 1'b0, 1'b0, 0, 0, 0);

        run_period("clear", 1'b0, 1'b1, 10, 16, 16);
        for (int k = 0; k < 3; k++)
            run_period("quiet", 1'b0, 1'b0, 0, 0, 0);
        run_period("coinc", 1'b0, 1'b1, P - 2, -40, 40);
        run_period("after", 1'b0, 1'b0, 0, 0, 0);

        for (int k = 0; k < 5; k++)
            run_period("lapse", 1'b0, 1'b0, 0, 0, 0);

        model_boundary();
        chk("mid/timed_out", int'(timed_out), int'(to));
        repeat (10) @(negedge clk);
        chk("mid/pre_ws", int'(wheel_signals), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid/ws", int'(wheel_signals), 0);
        chk("mid/pstart", int'(period_start), 0);
        chk("mid/timed_out_clr", int'(timed_out), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_period("reboot", 1'b1, 1'b0, 0, 0, 0);
        run_period("post", 1'b0, 1'b1, 5, 100, -100);
        run_period("post2", 1'b0, 1'b0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
